// File: rtl/vpu_src_port_burst_ctrl.sv
// Multi-beat source-operand fetcher: issues credited SRAM row reads for one
// command and pushes the returned rows into the operand queue.
module vpu_src_port_burst_ctrl #(
    parameter int DATA_W         = 256,
    parameter int BANK_CNT_LG2   = 2,
    parameter int BANK_DEPTH_LG2 = 10,
    parameter int ADDR_W         = BANK_CNT_LG2 + BANK_DEPTH_LG2,
    parameter int MAX_BEATS      = 8,
    parameter int MAX_OUTST      = 2,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic                                rvalid_i,
    input  logic [ADDR_W-1:0]                   raddr_i,
    input  logic [$clog2(MAX_BEATS+1)-1:0]      beats_i,
    input  logic                                reset_cmd_i,
    output logic                                done_o,
    output logic                                err_o,
    output logic                                sram_req_o,
    input  logic                                sram_ack_i,
    output logic [BANK_CNT_LG2-1:0]             sram_rid_o,
    output logic [BANK_DEPTH_LG2-1:0]           sram_addr_o,
    output logic                                sram_reb_o,
    output logic                                sram_rlast_o,
    input  logic                                sram_rvalid_i,
    input  logic [DATA_W-1:0]                   sram_rdata_i,
    output logic                                wren_o,
    output logic [DATA_W-1:0]                   wdata_o,
    input  logic                                fifo_pop_i
);

    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);
    localparam logic [CW-1:0] CRED_MAX  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

    state_t                    state;
    logic [BANK_CNT_LG2-1:0]   bank;
    logic [BANK_DEPTH_LG2-1:0] row;
    logic [BW-1:0]             beats;
    logic [BW-1:0]             issued;
    logic [BW-1:0]             received;
    logic [OW-1:0]             outst;
    logic [CW-1:0]             credits;

    logic req;
    logic issue;
    logic last_beat;
    logic ret;
    logic ret_err;
    logic pop_ok;
    logic pop_err;

    // Request is a pure function of registers, so it cannot glitch on inputs
    assign req       = (state == REQ) && (issued < beats) &&
                       (credits != '0) && (outst < OUTST_MAX);
    assign issue     = req && sram_ack_i;
    assign last_beat = (issued == beats - 1'b1);
    assign ret       = sram_rvalid_i && (outst != '0);
    assign ret_err   = sram_rvalid_i && (outst == '0);
    assign pop_ok    = fifo_pop_i && (credits != CRED_MAX);
    assign pop_err   = fifo_pop_i && (credits == CRED_MAX);

    assign ready_o      = (state == IDLE);
    assign done_o       = (state == DONE);
    assign sram_req_o   = req;
    assign sram_reb_o   = ~req;
    assign sram_rid_o   = req ? bank : '0;
    assign sram_addr_o  = req ? row : '0;
    assign sram_rlast_o = req && last_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bank     <= '0;
            row      <= '0;
            beats    <= '0;
            issued   <= '0;
            received <= '0;
            outst    <= '0;
            credits  <= CRED_MAX;
            err_o    <= 1'b0;
            wren_o   <= 1'b0;
            wdata_o  <= '0;
        end else begin
            wren_o <= ret;
            if (ret)
                wdata_o <= sram_rdata_i;
            if (issue) begin
                issued <= issued + 1'b1;
                row    <= row + 1'b1;
            end
            if (ret)
                received <= received + 1'b1;

            case ({issue, ret})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   outst <= outst - 1'b1;
                default: outst <= outst;
            endcase

            case ({issue, pop_ok})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase

            if (state == DONE && reset_cmd_i)
                err_o <= 1'b0;
            if (ret_err || pop_err)
                err_o <= 1'b1;

            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (rvalid_i && beats_i != '0) begin
                            bank     <= raddr_i[BANK_DEPTH_LG2 +: BANK_CNT_LG2];
                            row      <= raddr_i[BANK_DEPTH_LG2-1:0];
                            beats    <= beats_i;
                            issued   <= '0;
                            received <= '0;
                            state    <= REQ;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (issue && last_beat)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // Look ahead one return so done lines up with the last push
                    if (ret && (received + 1'b1) == beats)
                        state <= DONE;
                end
                DONE: begin
                    if (reset_cmd_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_src_port_burst_ctrl.sv
// Bench for vpu_src_port_burst_ctrl: cycle vector table plus SRAM/queue
// model driven sequences for bursts, limits, row wrap and mid-burst reset.
module tb_vpu_src_port_burst_ctrl;

    localparam int DW = 256;
    localparam int AW = 12;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic          ready_o;
    logic          rvalid_i;
    logic [AW-1:0] raddr_i;
    logic [BW-1:0] beats_i;
    logic          reset_cmd_i;
    logic          done_o;
    logic          err_o;
    logic          sram_req_o;
    logic          sram_ack_i;
    logic [1:0]    sram_rid_o;
    logic [9:0]    sram_addr_o;
    logic          sram_reb_o;
    logic          sram_rlast_o;
    logic          sram_rvalid_i;
    logic [DW-1:0] sram_rdata_i;
    logic          wren_o;
    logic [DW-1:0] wdata_o;
    logic          fifo_pop_i;

    logic          model_on;
    logic          tb_srv;
    logic [DW-1:0] tb_rdata;
    logic          mdl_srv;
    logic [DW-1:0] mdl_data;

    assign sram_rvalid_i = model_on ? mdl_srv : tb_srv;
    assign sram_rdata_i  = model_on ? mdl_data : tb_rdata;

    always #5 clk = ~clk;

    vpu_src_port_burst_ctrl #(
        .DATA_W(DW), .BANK_CNT_LG2(2), .BANK_DEPTH_LG2(10), .ADDR_W(AW),
        .MAX_BEATS(8), .MAX_OUTST(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .rvalid_i(rvalid_i), .raddr_i(raddr_i), .beats_i(beats_i),
        .reset_cmd_i(reset_cmd_i), .done_o(done_o), .err_o(err_o),
        .sram_req_o(sram_req_o), .sram_ack_i(sram_ack_i),
        .sram_rid_o(sram_rid_o), .sram_addr_o(sram_addr_o),
        .sram_reb_o(sram_reb_o), .sram_rlast_o(sram_rlast_o),
        .sram_rvalid_i(sram_rvalid_i), .sram_rdata_i(sram_rdata_i),
        .wren_o(wren_o), .wdata_o(wdata_o), .fifo_pop_i(fifo_pop_i)
    );

    typedef struct {
        logic        valid, rv;
        logic [11:0] raddr;
        logic [3:0]  beats;
        logic        rcmd, ack, srv;
        logic [15:0] rdata;
        logic        pop;
        logic        ready, done, err, req, rlast;
        logic [1:0]  rid;
        logic [9:0]  addr;
        logic        wren;
        logic [15:0] wdata;
    } vec_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } ret_t;

    int nvec  = 0;
    int nfail = 0;

    logic          d_rst, d_valid, d_rv, d_rcmd, d_ack, d_pop;
    logic [AW-1:0] d_raddr;
    logic [BW-1:0] d_beats;
    logic          auto_pop;
    ret_t          rq[$];
    int            cyc = 0;
    int            lat = 1;
    logic [1:0]    bank0;
    logic [9:0]    row0;
    int            nbeats, nissued, npushed, npopped;
    int            inflight, max_inflight, acks_pre;
    logic          seen_ret;

    function automatic logic [DW-1:0] pat(input logic [1:0] b, input logic [9:0] r);
        return {8{4'hD, 2'b00, b, 6'h00, r, 8'h5A}};
    endfunction

    function automatic vec_t mk(
        input logic valid, rv, input logic [11:0] raddr, input logic [3:0] beats,
        input logic rcmd, ack, srv, input logic [15:0] rdata, input logic pop,
        input logic ready, done, err, req, rlast, input logic [1:0] rid,
        input logic [9:0] addr, input logic wren, input logic [15:0] wdata);
        vec_t v;
        v.valid = valid; v.rv = rv; v.raddr = raddr; v.beats = beats;
        v.rcmd = rcmd; v.ack = ack; v.srv = srv; v.rdata = rdata; v.pop = pop;
        v.ready = ready; v.done = done; v.err = err; v.req = req;
        v.rlast = rlast; v.rid = rid; v.addr = addr; v.wren = wren;
        v.wdata = wdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        ret_t       r;
        logic [9:0] er;
        @(negedge clk);
        rst         = d_rst;
        valid_i     = d_valid;
        rvalid_i    = d_rv;
        raddr_i     = d_raddr;
        beats_i     = d_beats;
        reset_cmd_i = d_rcmd;
        sram_ack_i  = d_ack;
        fifo_pop_i  = d_pop;
        if (auto_pop && npushed > npopped) begin
            fifo_pop_i = 1'b1;
            npopped++;
        end
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            mdl_srv  = 1'b1;
            mdl_data = rq[0].data;
            void'(rq.pop_front());
        end else begin
            mdl_srv = 1'b0;
        end
        #1;
        if (sram_req_o) begin
            er = row0 + 10'(nissued);
            chk("req_beat", {sram_rid_o, sram_addr_o, sram_rlast_o, sram_reb_o},
                {bank0, er, nissued == nbeats - 1, 1'b0});
        end
        if (wren_o) begin
            chk("push_data", wdata_o, pat(bank0, row0 + 10'(npushed)));
            npushed++;
        end
        if (sram_rvalid_i) begin
            seen_ret = 1'b1;
            inflight--;
        end
        if (sram_req_o && sram_ack_i) begin
            if (!seen_ret) acks_pre++;
            r.due  = cyc + lat;
            r.data = pat(sram_rid_o, sram_addr_o);
            rq.push_back(r);
            nissued++;
            inflight++;
            if (inflight > max_inflight) max_inflight = inflight;
        end
        cyc++;
    endtask

    task automatic start_cmd(input logic [1:0] b, input logic [9:0] r,
                             input int n);
        bank0 = b; row0 = r; nbeats = n;
        nissued = 0; npushed = 0; npopped = 0;
        inflight = 0; max_inflight = 0; acks_pre = 0; seen_ret = 1'b0;
        d_valid = 1'b1; d_rv = 1'b1; d_raddr = {b, r}; d_beats = BW'(n);
        cycle();
        chk("cmd_ready", ready_o, 1'b1);
        d_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && !done_o; i++) cycle();
        chk("done_reached", done_o, 1'b1);
    endtask

    task automatic finish_cmd();
        d_rcmd = 1'b1;
        cycle();
        d_rcmd = 1'b0;
        cycle();
        chk("back_idle", {ready_o, done_o}, 2'b10);
    endtask

    vec_t vt[14];

    initial begin
        model_on = 1'b0; tb_srv = 1'b0; tb_rdata = '0;
        mdl_srv = 1'b0; mdl_data = '0;
        d_rst = 1'b1; d_valid = 1'b0; d_rv = 1'b0; d_rcmd = 1'b0;
        d_ack = 1'b0; d_pop = 1'b0; d_raddr = '0; d_beats = '0;
        auto_pop = 1'b0; bank0 = '0; row0 = '0; nbeats = 0;
        nissued = 0; npushed = 0; npopped = 0;
        inflight = 0; max_inflight = 0; acks_pre = 0; seen_ret = 1'b0;

        //           vl rv raddr  bt rc ak sv rdata  pp | rdy dn er rq rl rid addr  wr wdata
        vt[0]  = mk(1, 1, 'h405, 1, 0, 0, 0, 0,      0,  1, 0, 0, 0, 0, 0, 0,     0, 0);
        vt[1]  = mk(0, 0, 0,     0, 0, 1, 0, 0,      0,  0, 0, 0, 1, 1, 1, 'h005, 0, 0);
        vt[2]  = mk(0, 0, 0,     0, 0, 0, 1, 'hA5A5, 0,  0, 0, 0, 0, 0, 0, 0,     0, 0);
        vt[3]  = mk(0, 0, 0,     0, 0, 0, 0, 0,      0,  0, 1, 0, 0, 0, 0, 0,     1, 'hA5A5);
        vt[4]  = mk(0, 0, 0,     0, 1, 0, 0, 0,      0,  0, 1, 0, 0, 0, 0, 0,     0, 'hA5A5);
        vt[5]  = mk(0, 0, 0,     0, 0, 0, 0, 0,      1,  1, 0, 0, 0, 0, 0, 0,     0, 'hA5A5);
        vt[6]  = mk(1, 0, 'h123, 3, 0, 0, 0, 0,      0,  1, 0, 0, 0, 0, 0, 0,     0, 'hA5A5);
        vt[7]  = mk(0, 0, 0,     0, 0, 0, 0, 0,      1,  0, 1, 0, 0, 0, 0, 0,     0, 'hA5A5);
        vt[8]  = mk(0, 0, 0,     0, 1, 0, 0, 0,      0,  0, 1, 1, 0, 0, 0, 0,     0, 'hA5A5);
        vt[9]  = mk(1, 1, 'h200, 0, 0, 0, 0, 0,      0,  1, 0, 0, 0, 0, 0, 0,     0, 'hA5A5);
        vt[10] = mk(0, 0, 0,     0, 1, 0, 0, 0,      0,  0, 1, 0, 0, 0, 0, 0,     0, 'hA5A5);
        vt[11] = mk(0, 0, 0,     0, 0, 0, 1, 'hFFFF, 0,  1, 0, 0, 0, 0, 0, 0,     0, 'hA5A5);
        vt[12] = mk(0, 0, 0,     0, 1, 0, 0, 0,      0,  1, 0, 1, 0, 0, 0, 0,     0, 'hA5A5);
        vt[13] = mk(0, 0, 0,     0, 0, 0, 0, 0,      0,  1, 0, 1, 0, 0, 0, 0,     0, 'hA5A5);

        cycle();
        cycle();
        d_rst = 1'b0;
        cycle();
        chk("rst_vals",
            {ready_o, done_o, err_o, sram_req_o, sram_rlast_o, sram_rid_o,
             sram_addr_o, wren_o, sram_reb_o},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 10'h000, 1'b0, 1'b1});
        chk("rst_wdata", wdata_o, '0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            valid_i     = vt[i].valid;
            rvalid_i    = vt[i].rv;
            raddr_i     = vt[i].raddr;
            beats_i     = vt[i].beats;
            reset_cmd_i = vt[i].rcmd;
            sram_ack_i  = vt[i].ack;
            tb_srv      = vt[i].srv;
            tb_rdata    = DW'(vt[i].rdata);
            fifo_pop_i  = vt[i].pop;
            #1;
            chk($sformatf("vec%0d", i),
                {ready_o, done_o, err_o, sram_req_o, sram_rlast_o, sram_rid_o,
                 sram_addr_o, wren_o, wdata_o[15:0], sram_reb_o},
                {vt[i].ready, vt[i].done, vt[i].err, vt[i].req, vt[i].rlast,
                 vt[i].rid, vt[i].addr, vt[i].wren, vt[i].wdata, ~vt[i].req});
            cyc++;
        end
        tb_srv = 1'b0;
        model_on = 1'b1;

        // Null command to get back to DONE, where reset_cmd clears err
        d_valid = 1'b1; d_rv = 1'b0;
        cycle();
        d_valid = 1'b0;
        cycle();
        chk("null_done", {done_o, sram_req_o}, 2'b10);
        finish_cmd();
        chk("err_cleared", err_o, 1'b0);

        // Eight-beat burst against four credits, no consumer pops at first
        lat = 1; d_ack = 1'b1; auto_pop = 1'b0;
        start_cmd(2'd0, 10'h000, 8);
        repeat (10) cycle();
        chk("credit_stall_acks", nissued, 4);
        chk("credit_stall_req", sram_req_o, 1'b0);
        for (int k = 0; k < 4; k++) begin
            d_pop = 1'b1;
            cycle();
            d_pop = 1'b0;
            repeat (3) cycle();
            chk($sformatf("pop_release%0d", k), nissued, 5 + k);
        end
        wait_done();
        chk("burst_pushes", npushed, 8);
        d_pop = 1'b1;
        repeat (4) cycle();
        d_pop = 1'b0;
        finish_cmd();

        // Slow SRAM: outstanding limit bounds issue ahead of the first return
        lat = 4; auto_pop = 1'b1;
        start_cmd(2'd3, 10'h010, 8);
        wait_done();
        chk("outst_pre_ret", acks_pre, 2);
        chk("outst_max", max_inflight <= 2, 1'b1);
        chk("outst_pushes", npushed, 8);
        repeat (4) cycle();
        finish_cmd();

        // Row address wraps inside bank 2
        lat = 1;
        start_cmd(2'd2, 10'h3FE, 4);
        wait_done();
        chk("wrap_acks", nissued, 4);
        chk("wrap_pushes", npushed, 4);
        repeat (4) cycle();
        finish_cmd();

        // Reset after two of six acks; late returns must flag an error
        lat = 3; auto_pop = 1'b0;
        start_cmd(2'd1, 10'h020, 6);
        for (int i = 0; i < 20 && nissued < 2; i++) cycle();
        chk("pre_rst_acks", nissued, 2);
        d_rst = 1'b1;
        cycle();
        d_rst = 1'b0;
        npushed = 0;
        cycle();
        chk("mid_rst_vals",
            {ready_o, done_o, err_o, sram_req_o, sram_rlast_o, sram_rid_o,
             sram_addr_o, wren_o, sram_reb_o},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 10'h000, 1'b0, 1'b1});
        chk("mid_rst_wdata", wdata_o, '0);
        repeat (4) cycle();
        chk("late_ret_err", err_o, 1'b1);
        chk("late_ret_nopush", npushed, 0);

        // Full credit pool after reset: four beats issue with no pops
        lat = 1;
        start_cmd(2'd1, 10'h040, 4);
        wait_done();
        chk("post_rst_credits", nissued, 4);
        chk("post_rst_pushes", npushed, 4);
        finish_cmd();
        chk("err_clr_done", err_o, 1'b0);
        d_pop = 1'b1;
        repeat (4) cycle();
        d_pop = 1'b0;
        cycle();
        chk("no_pop_err", err_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
